elbeth_pipeline_ctrl: RTL

Parametrised pipeline sequencing controller for the ELBETH core. It generates per-stage stall and flush vectors and the PC source select for an NSTAGES-deep in-order pipeline. It arbitrates exceptions across stages, with the oldest stage winning, and sequences ERET with a programmable bubble count. It adds per-port memory watchdog timers that convert a hung instruction or data memory handshake into a bus-error exception. It sits beside the datapath; it does not decode instructions.

---
 rtl/elbeth_pipeline_ctrl_pkg.sv | 28 ++
 rtl/elbeth_mem_watchdog.sv | 37 +++
 rtl/elbeth_pipeline_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/elbeth_pipeline_ctrl_pkg.sv
// Shared encodings for the ELBETH pipeline controller: PC source select, FSM states, bus-error bits.
// Pure definitions; no timing or flow-control behaviour lives here.
package elbeth_pipeline_ctrl_pkg;

    localparam logic [1:0] PC_SEL_PC4    = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_EXC    = 2'd2;
    localparam logic [1:0] PC_SEL_EPC    = 2'd3;

    localparam int BUS_ERR_IMEM = 0;
    localparam int BUS_ERR_DMEM = 1;

    typedef enum logic {
        ST_RUN       = 1'b0,
        ST_ERET_WAIT = 1'b1
    } state_t;

    // Index of the highest set bit; the oldest requesting stage wins arbitration.
    function automatic logic [2:0] msb_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/elbeth_mem_watchdog.sv
// Memory handshake watchdog: counts consecutive wait cycles, pulses (combinationally) after MEM_TIMEOUT.
// Pending event registers on the pulse and holds until consumed; MEM_TIMEOUT = 0 disables it.
module elbeth_mem_watchdog #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_wait,
    input  logic consume,
    output logic timeout_pulse,
    output logic timeout_pending
);

    localparam logic             ENABLE = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(MEM_TIMEOUT);

    logic [CNT_W-1:0] cnt;

    assign timeout_pulse = ENABLE && mem_wait && (cnt == LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt             <= '0;
            timeout_pending <= 1'b0;
        end else begin
            if (!ENABLE || !mem_wait || timeout_pulse) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
            // A fresh pulse outranks a same-cycle consume so no timeout is lost.
            timeout_pending <= timeout_pulse | (timeout_pending & ~consume);
        end
    end

endmodule

// File: rtl/elbeth_pipeline_ctrl.sv
// Pipeline sequencer: per-stage stall/flush, PC select, oldest-first exception arbitration, ERET bubbles.
// Outputs are combinational from state and inputs; memory waits stall the pipe, watchdogs turn hangs into exceptions.
module elbeth_pipeline_ctrl
    import elbeth_pipeline_ctrl_pkg::*;
#(
    parameter int NSTAGES      = 3,
    parameter int ERET_BUBBLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               imem_en,
    input  logic               imem_ready,
    input  logic               dmem_en,
    input  logic               dmem_ready,
    input  logic               branch_taken,
    input  logic [NSTAGES-1:0] except_req,
    input  logic               eret,
    output logic [NSTAGES-1:0] stall,
    output logic [NSTAGES-1:0] flush,
    output logic               pc_stall,
    output logic [1:0]         pc_select,
    output logic               exception,
    output logic [2:0]         except_stage,
    output logic [1:0]         bus_error,
    output logic               retire
);

    state_t             state, state_nxt;
    logic [3:0]         bub, bub_nxt;
    logic               dstall, istall, run_stall;
    logic [1:0]         tmo_pulse, tmo_pend, consume;
    logic [NSTAGES-1:0] exc_v, flush_mask;
    logic [2:0]         win;

    assign dstall = dmem_en & ~dmem_ready;
    assign istall = imem_en & ~imem_ready;

    elbeth_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_imem_wd (
        .clk             (clk),
        .rst             (rst),
        .mem_wait        (istall),
        .consume         (consume[BUS_ERR_IMEM]),
        .timeout_pulse   (tmo_pulse[BUS_ERR_IMEM]),
        .timeout_pending (tmo_pend[BUS_ERR_IMEM])
    );

    elbeth_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_dmem_wd (
        .clk             (clk),
        .rst             (rst),
        .mem_wait        (dstall),
        .consume         (consume[BUS_ERR_DMEM]),
        .timeout_pulse   (tmo_pulse[BUS_ERR_DMEM]),
        .timeout_pending (tmo_pend[BUS_ERR_DMEM])
    );

    // Imem timeouts fault the fetch stage, dmem timeouts fault EXS.
    always_comb begin
        exc_v              = except_req;
        exc_v[0]           = exc_v[0] | tmo_pend[BUS_ERR_IMEM];
        exc_v[NSTAGES-1]   = exc_v[NSTAGES-1] | tmo_pend[BUS_ERR_DMEM];
        win                = msb_index(8'(exc_v));
        for (int i = 0; i < NSTAGES; i++) begin
            flush_mask[i] = (i <= int'(win));
        end
    end

    assign run_stall = dstall | (istall & ~eret);
    assign bus_error = tmo_pulse & {2{rst}};

    always_comb begin
        state_nxt    = state;
        bub_nxt      = bub;
        stall        = '0;
        flush        = '0;
        pc_stall     = 1'b0;
        pc_select    = PC_SEL_PC4;
        exception    = 1'b0;
        except_stage = '0;
        consume      = '0;
        if (!rst) begin
            stall    = '1;
            pc_stall = 1'b1;
        end else if (|exc_v) begin
            exception    = 1'b1;
            pc_select    = PC_SEL_EXC;
            except_stage = win;
            flush        = flush_mask;
            // A younger faulting stage still has to wait out an in-flight data access.
            if ((win != 3'(NSTAGES-1)) && dstall) begin
                stall    = '1;
                pc_stall = 1'b1;
            end
            consume[BUS_ERR_IMEM] = (win == 3'd0);
            consume[BUS_ERR_DMEM] = (win == 3'(NSTAGES-1));
            state_nxt = ST_RUN;
            bub_nxt   = '0;
        end else if (state == ST_RUN) begin
            stall[NSTAGES-2:0] = {(NSTAGES-1){run_stall}};
            stall[NSTAGES-1]   = dstall;
            pc_stall           = run_stall;
            if (eret) begin
                pc_select            = PC_SEL_EPC;
                flush[NSTAGES-2:0]   = '1;
                if (ERET_BUBBLES > 0) begin
                    state_nxt = ST_ERET_WAIT;
                    bub_nxt   = 4'(ERET_BUBBLES);
                end
            end else if (branch_taken) begin
                pc_select = PC_SEL_BRANCH;
                flush[0]  = 1'b1;
            end
        end else begin
            stall[NSTAGES-2:0] = '1;
            pc_stall           = 1'b1;
            bub_nxt            = bub - 4'd1;
            if (bub <= 4'd1) state_nxt = ST_RUN;
        end
    end

    assign retire = rst & ~stall[NSTAGES-1] & ~flush[NSTAGES-1] & ~exception & (state == ST_RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
            bub   <= '0;
        end else begin
            state <= state_nxt;
            bub   <= bub_nxt;
        end
    end

endmodule
